// File: rtl/imem_loader.sv
// Instruction-memory loader: takes a valid/ready byte stream, writes it from a base address,
// checks a trailing checksum byte, and holds the CPU until an image has loaded cleanly.
//
// state  | meaning
// IDLE   | no load yet since reset; CPU held
// LOAD   | accepting program bytes, one memory write per accepted byte
// CHECK  | accepting the checksum byte (not written)
// DONE   | image loaded with good checksum; CPU released
// ERR    | range or checksum failure; CPU held, err_o holds the code
module imem_loader #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 11
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  output logic              byte_ready_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [7:0]        wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [1:0]        err_o,
  output logic              cpu_hold_o
);

  // Wide enough that neither operand of base+len can wrap before the range compare.
  localparam int END_W = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 1;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_RANGE = 2'd1;
  localparam logic [1:0] ERR_CSUM  = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_count;
  logic [7:0]        r_sum;
  logic              r_byte_ready;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [7:0]        r_wdata;
  logic              r_busy;
  logic              r_done;
  logic [1:0]        r_err;
  logic              r_cpu_hold;

  logic              w_accept;
  logic              w_can_start;
  logic [END_W-1:0]  w_end;
  logic [END_W-1:0]  w_limit;
  logic              w_range_bad;
  logic              w_len_zero;
  logic              w_last_byte;
  logic [7:0]        w_sum_next;
  logic              w_sum_ok;

  assign w_accept    = byte_valid_i & r_byte_ready;
  assign w_can_start = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR);
  assign w_end       = END_W'(base_addr_i) + END_W'(len_i);
  assign w_limit     = END_W'(1) << ADDR_W;
  assign w_range_bad = (w_end > w_limit);
  assign w_len_zero  = (len_i == '0);
  // LOAD is only entered with len >= 1, so len-1 cannot underflow here.
  assign w_last_byte = (r_count == (r_len - LEN_W'(1)));
  assign w_sum_next  = r_sum + byte_data_i;
  assign w_sum_ok    = (w_sum_next == 8'h00);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_len        <= '0;
      r_count      <= '0;
      r_sum        <= '0;
      r_byte_ready <= 1'b0;
      r_we         <= 1'b0;
      r_waddr      <= '0;
      r_wdata      <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= ERR_NONE;
      r_cpu_hold   <= 1'b1;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start_i && w_can_start) begin
            r_ptr      <= base_addr_i;
            r_len      <= len_i;
            r_count    <= '0;
            r_sum      <= '0;
            r_done     <= 1'b0;
            r_cpu_hold <= 1'b1;
            if (w_range_bad) begin
              r_state      <= S_ERR;
              r_err        <= ERR_RANGE;
              r_byte_ready <= 1'b0;
              r_busy       <= 1'b0;
            end else begin
              r_state      <= w_len_zero ? S_CHECK : S_LOAD;
              r_err        <= ERR_NONE;
              r_byte_ready <= 1'b1;
              r_busy       <= 1'b1;
            end
          end
        end

        S_LOAD: begin
          if (w_accept) begin
            r_we    <= 1'b1;
            r_waddr <= r_ptr;
            r_wdata <= byte_data_i;
            r_ptr   <= r_ptr + ADDR_W'(1);
            r_count <= r_count + LEN_W'(1);
            r_sum   <= w_sum_next;
            if (w_last_byte) begin
              r_state <= S_CHECK;
            end
          end
        end

        S_CHECK: begin
          // Hold release happens here, one edge after the last data write was issued.
          if (w_accept) begin
            r_sum        <= w_sum_next;
            r_byte_ready <= 1'b0;
            r_busy       <= 1'b0;
            if (w_sum_ok) begin
              r_state    <= S_DONE;
              r_done     <= 1'b1;
              r_cpu_hold <= 1'b0;
            end else begin
              r_state <= S_ERR;
              r_err   <= ERR_CSUM;
            end
          end
        end

        default: begin
          r_state      <= S_IDLE;
          r_byte_ready <= 1'b0;
          r_busy       <= 1'b0;
          r_done       <= 1'b0;
          r_cpu_hold   <= 1'b1;
        end
      endcase
    end
  end

  assign byte_ready_o = r_byte_ready;
  assign we_o         = r_we;
  assign waddr_o      = r_waddr;
  assign wdata_o      = r_wdata;
  assign busy_o       = r_busy;
  assign done_o       = r_done;
  assign err_o        = r_err;
  assign cpu_hold_o   = r_cpu_hold;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected writes are queued as bytes are driven and
// matched (address, data, cycle) against the write port; status is checked after each step.
module tb_imem_loader;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [9:0]  base_addr_i;
  logic [10:0] len_i;
  logic        byte_valid_i;
  logic [7:0]  byte_data_i;
  logic        byte_ready_o;
  logic        we_o;
  logic [9:0]  waddr_o;
  logic [7:0]  wdata_o;
  logic        busy_o;
  logic        done_o;
  logic [1:0]  err_o;
  logic        cpu_hold_o;

  imem_loader #(.ADDR_W(10), .LEN_W(11)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .base_addr_i  (base_addr_i),
    .len_i        (len_i),
    .byte_valid_i (byte_valid_i),
    .byte_data_i  (byte_data_i),
    .byte_ready_o (byte_ready_o),
    .we_o         (we_o),
    .waddr_o      (waddr_o),
    .wdata_o      (wdata_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .cpu_hold_o   (cpu_hold_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [9:0] addr;
    logic [7:0] data;
    int         cyc;
  } wr_t;

  wr_t        sb_q[$];
  logic [7:0] mem [0:1023];
  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;
  int         n_writes = 0;
  logic [9:0] m_ptr;
  logic [7:0] m_sum;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Write-port monitor: every we_o pulse must match the oldest queued expectation.
  always @(negedge clk_i) begin
    if (we_o === 1'b1) begin
      wr_t e;
      n_writes++;
      tests++;
      assert (sb_q.size() > 0) else begin
        fails++;
        $error("FAIL unexpected_write: got addr=%0d data=0x%02h, required no write", waddr_o, wdata_o);
      end
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        tests++;
        assert (waddr_o === e.addr && wdata_o === e.data && cyc == e.cyc) else begin
          fails++;
          $error("FAIL write: got addr=%0d data=0x%02h cyc=%0d, required addr=%0d data=0x%02h cyc=%0d",
                 waddr_o, wdata_o, cyc, e.addr, e.data, e.cyc);
        end
      end
      mem[waddr_o] = wdata_o;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h, required 0x%0h", tag, obs, exp);
    end
  endtask

  // {byte_ready, busy, done, err[1:0], cpu_hold}
  function automatic logic [5:0] status();
    return {byte_ready_o, busy_o, done_o, err_o, cpu_hold_o};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_start(input logic [9:0] b, input logic [10:0] l);
    start_i     = 1'b1;
    base_addr_i = b;
    len_i       = l;
    m_ptr       = b;
    m_sum       = 8'h00;
    tick();
    start_i     = 1'b0;
  endtask

  // Drive one byte and wait (bounded) for it to be accepted.
  task automatic send_byte(input logic [7:0] b, input logic is_data);
    int n;
    n = 0;
    byte_valid_i = 1'b1;
    byte_data_i  = b;
    @(negedge clk_i);
    while (byte_ready_o !== 1'b1 && n < 20) begin
      n++;
      @(negedge clk_i);
    end
    chk("byte_ready_wait", byte_ready_o, 1'b1);
    if (byte_ready_o === 1'b1 && is_data) begin
      sb_q.push_back('{addr: m_ptr, data: b, cyc: cyc + 1});
      m_ptr = m_ptr + 10'd1;
    end
    if (is_data) m_sum = m_sum + b;
    tick();
    byte_valid_i = 1'b0;
  endtask

  task automatic send_csum(input logic [7:0] delta);
    logic [7:0] cs;
    cs = 8'h00 - m_sum + delta;
    send_byte(cs, 1'b0);
  endtask

  initial begin
    int         w0;
    logic       seen_ready;
    logic [7:0] prog [4];
    prog[0] = 8'h30; prog[1] = 8'hF2; prog[2] = 8'h0A; prog[3] = 8'h00;

    rst_i = 1'b1; start_i = 1'b0; base_addr_i = '0; len_i = '0;
    byte_valid_i = 1'b0; byte_data_i = '0;
    m_ptr = '0; m_sum = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'hxx;
    repeat (3) tick();
    chk("reset_ctl", {byte_ready_o, we_o, busy_o, done_o, err_o, cpu_hold_o}, 7'b0000001);
    chk("reset_addr_data", {waddr_o, wdata_o}, 18'd0);
    rst_i = 1'b0;
    tick();
    chk("idle_status", status(), 6'b000001);

    // Normal load
    w0 = n_writes;
    do_start(10'd0, 11'd4);
    chk("normal_start_status", status(), 6'b110001);
    for (int i = 0; i < 4; i++) send_byte(prog[i], 1'b1);
    send_csum(8'h00);
    chk("normal_done_status", status(), 6'b001000);
    chk("normal_sb_empty", sb_q.size(), 0);
    chk("normal_writes", n_writes - w0, 4);
    chk("fetch_icode", {28'd0, mem[0][7:4]}, 32'd3);
    tick();

    // Bad checksum, then a good load recovers
    w0 = n_writes;
    do_start(10'd0, 11'd4);
    chk("restart_hold", status(), 6'b110001);
    for (int i = 0; i < 4; i++) send_byte(prog[i], 1'b1);
    send_csum(8'h01);
    chk("badcs_status", status(), 6'b000101);
    chk("badcs_writes", n_writes - w0, 4);
    tick();
    do_start(10'd16, 11'd4);
    chk("err_cleared_on_start", status(), 6'b110001);
    for (int i = 0; i < 4; i++) send_byte(8'h11 * (i + 1), 1'b1);
    send_csum(8'h00);
    chk("recover_status", status(), 6'b001000);

    // Range error: nothing accepted or written
    w0 = n_writes;
    do_start(10'd1020, 11'd5);
    chk("range_status", status(), 6'b000011);
    seen_ready = 1'b0;
    byte_valid_i = 1'b1;
    byte_data_i  = 8'hAA;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      seen_ready |= byte_ready_o;
    end
    byte_valid_i = 1'b0;
    tick();
    chk("range_never_ready", seen_ready, 1'b0);
    chk("range_no_writes", n_writes - w0, 0);
    chk("range_err_held", status(), 6'b000011);

    // Boundary: last four bytes of memory
    w0 = n_writes;
    do_start(10'd1020, 11'd4);
    chk("boundary_start", status(), 6'b110001);
    for (int i = 0; i < 4; i++) send_byte(8'h10 * (i + 1), 1'b1);
    send_csum(8'h00);
    chk("boundary_done", status(), 6'b001000);
    chk("boundary_writes", n_writes - w0, 4);
    chk("boundary_last_byte", mem[1023], 8'h40);

    // Zero length
    w0 = n_writes;
    do_start(10'd100, 11'd0);
    chk("zero_len_check_state", status(), 6'b110001);
    send_byte(8'h00, 1'b0);
    chk("zero_len_done", status(), 6'b001000);
    chk("zero_len_no_writes", n_writes - w0, 0);

    // Bubbles between bytes
    w0 = n_writes;
    do_start(10'd200, 11'd3);
    send_byte(8'h5A, 1'b1);
    tick();
    send_byte(8'hC3, 1'b1);
    tick();
    chk("bubble_still_loading", status(), 6'b110001);
    send_byte(8'h07, 1'b1);
    send_csum(8'h00);
    chk("bubble_done", status(), 6'b001000);
    chk("bubble_writes", n_writes - w0, 3);

    // Reset after 2 of 6 bytes
    do_start(10'd50, 11'd6);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    rst_i = 1'b1;
    tick();
    chk("midrst_ctl", {byte_ready_o, we_o, busy_o, done_o, err_o, cpu_hold_o}, 7'b0000001);
    chk("midrst_addr_data", {waddr_o, wdata_o}, 18'd0);
    rst_i = 1'b0;
    tick();
    chk("midrst_sb_empty", sb_q.size(), 0);
    chk("midrst_mem_kept", mem[51], 8'h02);

    // start_i during LOAD is ignored
    w0 = n_writes;
    do_start(10'd300, 11'd4);
    send_byte(8'h21, 1'b1);
    start_i = 1'b1; base_addr_i = 10'd500; len_i = 11'd1;
    tick();
    start_i = 1'b0;
    chk("start_ignored_status", status(), 6'b110001);
    send_byte(8'h22, 1'b1);
    send_byte(8'h23, 1'b1);
    send_byte(8'h24, 1'b1);
    send_csum(8'h00);
    chk("start_ignored_done", status(), 6'b001000);
    chk("start_ignored_writes", n_writes - w0, 4);
    tick();
    chk("final_sb_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
